// File: rtl/instr_fetch_prefetcher.sv
// Instruction fetch prefetcher: issues sequential word reads to the instruction
// memory port (1-cycle fixed latency, at most one read in flight), buffers the
// returned words in a small FIFO and presents them to the fetch stage over a
// valid/ready handshake. A branch flushes the buffer and restarts fetching.
module instr_fetch_prefetcher #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en_i,
  input  logic                    branch_i,
  input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
  output logic                    fetch_valid_o,
  input  logic                    fetch_ready_i,
  output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0]   fetch_addr_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  // Occupancy (count + pending) can reach FIFO_DEPTH + 1 bits worth, so one extra bit.
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WordInc = ADDR_WIDTH'(4);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic [ADDR_WIDTH-1:0] branch_aligned;
  logic [CntW:0]         occupancy;
  logic                  push, pop;

  assign branch_aligned = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  // Registered occupancy plus the in-flight read; a same-cycle pop is not credited.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, pending_q};

  // Write side of the port is never used.
  assign mem_we_o    = 1'b0;
  assign mem_be_o    = '1;
  assign mem_wdata_o = '0;

  // Head of the FIFO drives the fetch interface straight from registers.
  assign fetch_valid_o = (count_q != '0);
  assign fetch_rdata_o = fifo_data_q[rd_ptr_q];
  assign fetch_addr_o  = fifo_addr_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first redirect starts fetching; only reset returns to idle.
  always_comb begin
    state_d = state_q;
    if (branch_i) begin
      state_d = StRun;
    end
  end

  // Outputs and datapath next-state: issue decision, fetch pointer, push/pop.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = next_addr_q;
    next_addr_d = next_addr_q;
    pend_addr_d = pend_addr_q;
    // A response landing in a branch cycle belongs to the old stream.
    push        = pending_q & ~branch_i;
    pop         = fetch_valid_o & fetch_ready_i & ~branch_i;

    if (branch_i) begin
      mem_en_o    = fetch_en_i;
      mem_addr_o  = branch_aligned;
      next_addr_d = fetch_en_i ? branch_aligned + WordInc : branch_aligned;
    end else if (state_q == StRun) begin
      mem_en_o = fetch_en_i & (occupancy < DepthOcc);
      if (mem_en_o) begin
        next_addr_d = next_addr_q + WordInc;
      end
    end

    if (mem_en_o) begin
      pend_addr_d = mem_addr_o;
    end
    pending_d = mem_en_o;
  end

  // Fetch pointer and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      next_addr_q <= next_addr_d;
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy; a branch empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else if (branch_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rdata_i;
        fifo_addr_q[wr_ptr_q] <= pend_addr_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntOne;
      end else if (pop && !push) begin
        count_q <= count_q - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_prefetcher.sv
// Self-checking bench for instr_fetch_prefetcher against a queue-based model of
// the word stream: every issued word is owed to the core in address order.
module tb_instr_fetch_prefetcher;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [DW-1:0] KEY = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en_i;
  logic          branch_i;
  logic [AW-1:0] branch_addr_i;
  logic          fetch_valid_o;
  logic          fetch_ready_i;
  logic [DW-1:0] fetch_rdata_o;
  logic [AW-1:0] fetch_addr_o;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_prefetcher #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_addr_o  (fetch_addr_o),
    .mem_en_o      (mem_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ KEY;
  endfunction

  // Memory: data for a read issued in cycle T is on the bus during T+1; junk otherwise.
  always @(posedge clk) begin
    mem_rdata_i <= mem_en_o ? word_of(mem_addr_o) : $urandom();
  end

  // Reference model: queue of words owed to the core (in flight or buffered).
  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } ent_t;

  ent_t          mq[$];
  bit            m_run;
  logic [AW-1:0] m_next;
  int            cyc;

  // A word is presentable two cycles after its read was issued.
  function automatic bit head_ready();
    if (mq.size() == 0) return 1'b0;
    return (mq[0].cyc + 2 <= cyc);
  endfunction

  function automatic logic model_issue();
    if (branch_i) return fetch_en_i;
    return m_run && fetch_en_i && (mq.size() < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_run  = 1'b0;
      m_next = '0;
      cyc    = 0;
    end else begin
      bit            hr;
      logic          iss;
      logic [AW-1:0] a;
      hr  = head_ready();
      iss = model_issue();
      if (branch_i) begin
        mq.delete();
        m_run = 1'b1;
        a = {branch_addr_i[AW-1:2], 2'b00};
        if (iss) mq.push_back('{addr: a, cyc: cyc});
        m_next = iss ? a + AW'(4) : a;
      end else begin
        if (hr && fetch_ready_i) void'(mq.pop_front());
        if (iss) begin
          mq.push_back('{addr: m_next, cyc: cyc});
          m_next = m_next + AW'(4);
        end
      end
      cyc = cyc + 1;
    end
  end

  // {valid, head addr, head data, mem_en, mem_addr}; don't-care fields zeroed.
  function automatic logic [1+AW+DW+1+AW-1:0] exp_vec();
    logic          v;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          en;
    logic [AW-1:0] ma;
    v  = head_ready();
    ha = '0;
    hd = '0;
    if (v) begin
      ha = mq[0].addr;
      hd = word_of(ha);
    end
    en = model_issue();
    ma = '0;
    if (en) ma = branch_i ? {branch_addr_i[AW-1:2], 2'b00} : m_next;
    return {v, ha, hd, en, ma};
  endfunction

  function automatic logic [1+AW+DW+1+AW-1:0] obs_vec();
    return {fetch_valid_o,
            fetch_valid_o ? fetch_addr_o : '0,
            fetch_valid_o ? fetch_rdata_o : '0,
            mem_en_o,
            mem_en_o ? mem_addr_o : '0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_en_i = 1'b0;
    branch_i = 1'b0;
    branch_addr_i = '0;
    fetch_ready_i = 1'b0;
    #12;
    vectors++;
    if ({fetch_valid_o, fetch_rdata_o, fetch_addr_o, mem_en_o, mem_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h a=%h en=%b ma=%h, expected all zero",
               fetch_valid_o, fetch_rdata_o, fetch_addr_o, mem_en_o, mem_addr_o);
    end
    vectors++;
    if ({mem_we_o, mem_be_o, mem_wdata_o} !== {1'b0, {(DW/8){1'b1}}, {DW{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_constants: got we=%b be=%h wdata=%h, expected we=0 be=f wdata=0",
               mem_we_o, mem_be_o, mem_wdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    int first_valid = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fetch_en_i = 1'b1;
      fetch_ready_i = 1'b1;
      branch_i = (i == 0);
      branch_addr_i = 16'h8000;
      #1;
      if (fetch_valid_o && first_valid < 0) first_valid = i;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sequential cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (first_valid != 2) begin
      miscompares++;
      $display("FAIL sequential_latency: got first valid at %0d, expected 2", first_valid);
    end
  endtask

  task automatic test_full();
    int issues = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fetch_en_i = 1'b1;
      fetch_ready_i = 1'b0;
      branch_i = (i == 0);
      branch_addr_i = 16'h0100;
      #1;
      if (mem_en_o) issues++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL full_fill cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (issues != DEPTH) begin
      miscompares++;
      $display("FAIL full_issue_count: got %0d reads, expected %0d", issues, DEPTH);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      branch_i = 1'b0;
      fetch_ready_i = 1'b1;
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL full_drain cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    logic [AW-1:0] first_addr = '1;
    bit            seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fetch_en_i = 1'b1;
      fetch_ready_i = (i > 4);
      branch_i = (i == 0) || (i == 4);
      branch_addr_i = (i == 0) ? 16'h0200 : 16'h0040;
      #1;
      if (i > 4 && fetch_valid_o && !seen) begin
        seen = 1'b1;
        first_addr = fetch_addr_o;
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL flush cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (first_addr !== 16'h0040) begin
      miscompares++;
      $display("FAIL flush_first_word: got addr %h, expected 0040", first_addr);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fetch_en_i = 1'b1;
      fetch_ready_i = 1'b1;
      branch_i = (i == 0);
      branch_addr_i = 16'hFFFC;
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fetch_en_gap();
    int gap_issues = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      fetch_en_i = !(i >= 6 && i < 11);
      fetch_ready_i = 1'b1;
      branch_i = (i == 0);
      branch_addr_i = 16'h7FF0;
      #1;
      if (i >= 6 && i < 11 && mem_en_o) gap_issues++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL fetch_en_gap cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (gap_issues != 0) begin
      miscompares++;
      $display("FAIL fetch_en_gap_issue: got %0d reads during gap, expected 0", gap_issues);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      fetch_en_i = ($urandom_range(3) != 0);
      fetch_ready_i = ($urandom_range(2) != 0);
      branch_i = ($urandom_range(24) == 0);
      branch_addr_i = AW'($urandom());
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      fetch_en_i = 1'b1;
      fetch_ready_i = (i != 2);
      branch_i = (i == 0);
      branch_addr_i = 16'h0400;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({fetch_valid_o, fetch_rdata_o, fetch_addr_o, mem_en_o, mem_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b d=%h a=%h en=%b ma=%h, expected all zero",
               fetch_valid_o, fetch_rdata_o, fetch_addr_o, mem_en_o, mem_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      fetch_en_i = 1'b1;
      fetch_ready_i = 1'b1;
      branch_i = (i == 6);
      branch_addr_i = 16'h0023;
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL after_reset cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_flush();
    test_wrap();
    test_fetch_en_gap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
